// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared types and default sizing for the SRAM port controller.
// Contents: controller FSM state enum, default macro geometry, response buffer depth.
// No logic; imported by sram_port_ctrl and resp_fifo2.
package sram_port_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    SCRUB = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam int SRAM_DEPTH  = 512;
  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_MASK_W = 8;

  // Response buffer depth; the read credit limit is tied to this value.
  localparam int RESP_DEPTH  = 2;
  localparam int RESP_CNT_W  = $clog2(RESP_DEPTH + 1);

endpackage

// File: rtl/resp_fifo2.sv
// resp_fifo2: 2-entry read-response buffer between the SRAM read port and the consumer.
// Latency: pushed data is visible at the head the cycle after the push.
// Backpressure: none internally; the caller's credit logic guarantees no push when full
//               unless a pop happens in the same cycle.
// Ports: clk_i/rst_i (async, active-high), push_i/push_data_i, pop_i, cnt_o (0..2), head_o.
module resp_fifo2
  import sram_port_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  pop_i,
  output logic [RESP_CNT_W-1:0] cnt_o,
  output logic [DATA_W-1:0]     head_o
);

  logic [DATA_W-1:0]     mem_q [RESP_DEPTH];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [RESP_CNT_W-1:0] cnt_q;
  logic [RESP_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push_i && !pop_i) begin
      cnt_d = cnt_q + RESP_CNT_W'(1);
    end else if (pop_i && !push_i) begin
      cnt_d = cnt_q - RESP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ~wr_ptr_q;
      if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: cnt_q qualifies every entry. When full, a push
  // overwrites the slot being popped in the same cycle, whose data has
  // already been consumed from head_o.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign cnt_o  = cnt_q;
  assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: ready/valid front-end for a 1W/1R synchronous-read SRAM macro.
// Latency: write commits at the end of the fire cycle; read fires in N, resp_valid in N+2.
// Backpressure: reads stall (req_ready low) when 2 responses are buffered or owed; writes never stall.
// Ports: clk_i, rst_i (async, active-high); req_* request channel; resp_* response channel;
//        scrub_busy_o; W0_* SRAM write port; R0_* SRAM read port (R0_data_i valid the cycle after R0_en_o).
// Build option: SRAM_PORT_CTRL_SCRUB_EN zero-fills the array after reset before accepting traffic.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int MASK_W = SRAM_MASK_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [MASK_W-1:0] req_mask_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              scrub_busy_o,
  output logic              W0_en_o,
  output logic [ADDR_W-1:0] W0_addr_o,
  output logic [DATA_W-1:0] W0_data_o,
  output logic [MASK_W-1:0] W0_mask_o,
  output logic              R0_en_o,
  output logic [ADDR_W-1:0] R0_addr_o,
  input  logic [DATA_W-1:0] R0_data_i
);

  if (($clog2(DEPTH) != ADDR_W) || ((DATA_W % MASK_W) != 0)) begin : g_cfg_err
    $error("sram_port_ctrl: ADDR_W must be clog2(DEPTH) and DATA_W a multiple of MASK_W");
  end

  state_e                state_q;
  logic                  inflight_q;
  logic                  inflight_d;
  logic [RESP_CNT_W-1:0] cnt;
  logic                  pop;
  logic                  read_ok;
  logic                  fire;

`ifdef SRAM_PORT_CTRL_SCRUB_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] scrub_cnt_q;
  logic              scrub_busy_q;
`endif

  assign pop = resp_valid_o && resp_ready_i;

  // Buffered + owed responses, net of the one leaving this cycle, must leave
  // room for one more. Compared as cnt + inflight < RESP_DEPTH + pop so the
  // arithmetic never goes negative.
  assign read_ok = ({1'b0, cnt} + {{RESP_CNT_W{1'b0}}, inflight_q})
                   < ((RESP_CNT_W + 1)'(RESP_DEPTH) + {{RESP_CNT_W{1'b0}}, pop});

  assign req_ready_o = (state_q == RUN) && (req_write_i || read_ok);
  assign fire        = req_valid_i && req_ready_o;
  assign inflight_d  = fire && !req_write_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= INIT;
      inflight_q   <= 1'b0;
`ifdef SRAM_PORT_CTRL_SCRUB_EN
      scrub_cnt_q  <= '0;
      scrub_busy_q <= 1'b0;
`endif
    end else begin
      inflight_q <= inflight_d;
      case (state_q)
`ifdef SRAM_PORT_CTRL_SCRUB_EN
        INIT: begin
          state_q      <= SCRUB;
          scrub_busy_q <= 1'b1;
        end
        SCRUB: begin
          if (scrub_cnt_q == LAST_ADDR) begin
            state_q      <= RUN;
            scrub_busy_q <= 1'b0;
          end else begin
            scrub_cnt_q <= scrub_cnt_q + ADDR_W'(1);
          end
        end
`else
        INIT:    state_q <= RUN;
`endif
        RUN:     state_q <= RUN;
        default: state_q <= INIT;
      endcase
    end
  end

  // Write port: request pass-through in RUN, overridden by the scrubber.
  always_comb begin
    W0_en_o   = fire && req_write_i;
    W0_addr_o = req_addr_i;
    W0_data_o = req_data_i;
    W0_mask_o = req_mask_i;
`ifdef SRAM_PORT_CTRL_SCRUB_EN
    if (state_q == SCRUB) begin
      W0_en_o   = 1'b1;
      W0_addr_o = scrub_cnt_q;
      W0_data_o = '0;
      W0_mask_o = '1;
    end
`endif
  end

  assign R0_en_o   = fire && !req_write_i;
  assign R0_addr_o = req_addr_i;

`ifdef SRAM_PORT_CTRL_SCRUB_EN
  assign scrub_busy_o = scrub_busy_q;
`else
  assign scrub_busy_o = 1'b0;
`endif

  // Macro read data is valid exactly one cycle after R0_en, i.e. while inflight_q is set.
  resp_fifo2 #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (R0_data_i),
    .pop_i       (pop),
    .cnt_o       (cnt),
    .head_o      (resp_data_o)
  );

  assign resp_valid_o = (cnt != '0);

endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Decoupled request/response front-end that sits directly upstream of a one-write-port, one-read-port synchronous-read SRAM macro, default 512 x 64 with an 8-bit byte mask. It turns a single ready/valid request channel (reads and writes) into the macro's W0/R0 enables, and captures read data the cycle after issue into a 2-entry response buffer so the consumer can apply backpressure. Optionally it zero-scrubs the whole array after reset before accepting traffic.

## Interface
- DEPTH, 512, number of SRAM entries
- ADDR_W, 9, address width, equal to clog2(DEPTH)
- DATA_W, 64, data width
- MASK_W, 8, write-mask width; DATA_W must be divisible by MASK_W
- clock  in  1  single clock for the block; the macro's W0_clk and R0_clk are tied to it at the parent
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  entry address
- req_data  in  DATA_W  write data
- req_mask  in  MASK_W  byte-lane write enables
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes resp_data
- resp_data  out  DATA_W  read data, returned in request order
- scrub_busy  out  1  initial scrub in progress
- W0_en, W0_addr, W0_data, W0_mask  out  1/ADDR_W/DATA_W/MASK_W  SRAM write port
- R0_en, R0_addr  out  1/ADDR_W  SRAM read port
- R0_data  in  DATA_W  SRAM read data, valid in the cycle after R0_en

## Operation
- FSM states: INIT, SCRUB, RUN. Reset enters INIT. INIT goes to SCRUB on the next cycle when SCRUB_EN is defined, otherwise to RUN. SCRUB goes to RUN after the write to address DEPTH-1.
- SCRUB state:
  - W0_en=1, W0_addr=scrub counter (starts at 0, increments by 1 per cycle), W0_data=0, W0_mask=all ones.
  - req_ready=0 and scrub_busy=1.
- Write in RUN: a fire with req_write=1 drives W0_en=1 and passes addr/data/mask through combinationally. It never stalls for response credit.
- Read in RUN:
  - A fire with req_write=0 drives R0_en=1 and R0_addr=req_addr, and sets inflight=1 for the next cycle.
  - In the cycle where inflight=1, R0_data is pushed into the response FIFO.
- Credit rule: read ready = (cnt + inflight - (resp_valid && resp_ready)) < 2, where cnt is FIFO occupancy 0..2.
  - req_ready = (state==RUN) && (req_write || read ready).
  - This is a combinational path from resp_ready to req_ready, which is intended.
- The FIFO never overflows; the credit rule guarantees it. Push and pop in the same cycle is legal at cnt=1 and at cnt=2.
- resp_valid = (cnt != 0). resp_data = FIFO head.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, W0_en=0, R0_en=0, scrub_busy=0.
  - The FIFO is empty, inflight=0, and the scrub counter is 0.
- INIT lasts exactly 1 cycle.
- SCRUB lasts exactly DEPTH cycles; scrub_busy is high throughout.
- Read latency: request fires in cycle N, data is captured at the end of N+1, resp_valid is high in N+2.
- Sustained throughput is 1 read/cycle while resp_ready=1.
- Write fired in N, then read of the same address fired in N+1: the read returns the new data.
- Read fired in N, then write of the same address fired in N+1: the read returns the old data, because capture happens in N+1 before the write commits.
- Reset asserted mid-operation:
  - The FIFO and inflight are cleared and any in-flight read is dropped, with no response.
  - The scrub restarts from address 0.

## Configuration
- Macro SRAM_PORT_CTRL_SCRUB_EN.
- Defined: INIT->SCRUB->RUN as above; after reset the array reads all-zero.
- Undefined:
  - INIT->RUN, and the SCRUB state and scrub counter are not compiled in.
  - scrub_busy is tied to 0.
  - Array contents after reset are whatever the macro holds.

## Structure
- Package sram_port_pkg holds:
  - the state enum (INIT, SCRUB, RUN);
  - default constants SRAM_DEPTH=512, SRAM_ADDR_W=9, SRAM_DATA_W=64, SRAM_MASK_W=8;
  - the FIFO depth constant RESP_DEPTH=2.
- One sub-module, resp_fifo2: a 2-entry DATA_W FIFO with push, pop, cnt, head and asynchronous active-high reset.
- The FSM, scrub counter, credit logic and inflight flag live in sram_port_ctrl.

## Test plan
- Reset with SRAM_PORT_CTRL_SCRUB_EN defined: scrub_busy is high for 512 cycles, W0_addr runs 0..511, then req_ready rises. A read of addr 0x1FF returns 0 at N+2.
- Write addr 5, data 0xDEADBEEF_01234567, mask 0xFF. Read addr 5 on the next cycle -> resp_data=0xDEADBEEF_01234567 two cycles after the read fires.
- Write addr 7 with data 0x0 and mask 0xFF, then write addr 7 with data all-ones and mask 0x0F. A read of addr 7 returns 0x00000000_FFFFFFFF.
- Hold resp_ready=0 and issue 4 back-to-back reads: only 2 are accepted, cnt saturates at 2, and req_ready stays 0 for reads. A write issued meanwhile is accepted. With resp_ready=1 afterwards, the responses drain in order.
- Read addr 3 (old value 0x11) in N and write addr 3 with 0x22 in N+1: the response is 0x11, and a subsequent read returns 0x22.
- Assert reset with one read in flight and cnt=1: no response appears after reset, resp_valid=0, and the scrub restarts at address 0.
